// File: rtl/sa_mm_responder.sv
// ============================================================================
//  Module   : sa_mm_responder
//  Brief    : Sequential matrix-multiply responder for the systolic-array
//             request interface. It accumulates one K-slice per cycle, pulses
//             O_PE_SHIFT at each k-chunk end and returns a saturated
//             SA_R x SA_C result with a one-cycle valid.
//  Revision : 1.0 - initial release
// ============================================================================
//  Packed operand layout (element 0 at the LSBs):
//    X[i][k] -> I_X_MATRIX[(i*K_MAX + k)*D_W +: D_W]
//    W[k][j] -> I_W_MATRIX[(k*SA_C  + j)*D_W +: D_W]
//    R[i][j] -> O_OUT     [(i*SA_C  + j)*D_W +: D_W]
// ============================================================================
`default_nettype none

module sa_mm_responder #(
    parameter int D_W   = 8,
    parameter int SA_R  = 16,
    parameter int SA_C  = 16,
    parameter int K_MAX = 128,
    parameter int FRAC  = 0
) (
    input  logic                      I_CLK,
    input  logic                      I_SYNC_RSTN,
    input  logic                      I_START_FLAG,
    input  logic [7:0]                I_M_DIM,
    input  logic [SA_R*K_MAX*D_W-1:0] I_X_MATRIX,
    input  logic [K_MAX*SA_C*D_W-1:0] I_W_MATRIX,
    output logic                      O_BUSY,
    output logic                      O_PE_SHIFT,
    output logic                      O_OUT_VLD,
    output logic [SA_R*SA_C*D_W-1:0]  O_OUT
);

    // Accumulator is wide enough that K_MAX full-scale products never wrap.
    localparam int ACC_W = 2*D_W + $clog2(K_MAX) + 1;
    localparam int K_W   = $clog2(K_MAX + 1);
    localparam int C_W   = (SA_C > 1) ? $clog2(SA_C) : 1;

    localparam logic [K_W-1:0] K_LIMIT    = K_W'(K_MAX);
    localparam logic [C_W-1:0] CHUNK_LAST = C_W'(SA_C - 1);

    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(D_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2**(D_W-1)));

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]     state;
    logic [K_W-1:0] k;
    logic [K_W-1:0] m;
    logic [C_W-1:0] chunk;
    logic [K_W-1:0] m_req;
    logic           start_acc;
    logic           last_k;
    logic           load_zero;
    logic           pe_shift;
    logic           out_vld;

    logic signed [D_W-1:0] x_col [SA_R];
    logic signed [D_W-1:0] w_row [SA_C];

    // Shift the accumulator by FRAC and clamp into the signed D_W range.
    function automatic logic signed [D_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] s;
        s = v >>> FRAC;
        if (s > SAT_HI) begin
            return SAT_HI[D_W-1:0];
        end
        if (s < SAT_LO) begin
            return SAT_LO[D_W-1:0];
        end
        return s[D_W-1:0];
    endfunction

    // Requested depth clamped to K_MAX; only used at an accepted start.
    always_comb begin
        m_req = K_LIMIT;
        if (int'(I_M_DIM) < K_MAX) begin
            m_req = K_W'(I_M_DIM);
        end
    end

    assign start_acc = (state == ST_IDLE) && I_START_FLAG;
    assign load_zero = start_acc && (m_req == '0);
    assign last_k    = (state == ST_MAC) && (k == (m - K_W'(1)));

    // Pick column k of X and row k of W for the current MAC step.
    always_comb begin
        for (int i = 0; i < SA_R; i++) begin
            x_col[i] = I_X_MATRIX[(i*K_MAX + int'(k))*D_W +: D_W];
        end
        for (int j = 0; j < SA_C; j++) begin
            w_row[j] = I_W_MATRIX[(int'(k)*SA_C + j)*D_W +: D_W];
        end
    end

    // Control FSM: step counter, chunk counter and the registered pulses.
    always_ff @(posedge I_CLK) begin
        if (!I_SYNC_RSTN) begin
            state    <= ST_IDLE;
            k        <= '0;
            m        <= '0;
            chunk    <= '0;
            pe_shift <= 1'b0;
            out_vld  <= 1'b0;
        end else begin
            pe_shift <= 1'b0;
            out_vld  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (I_START_FLAG) begin
                        m     <= m_req;
                        k     <= '0;
                        chunk <= '0;
                        if (m_req == '0) begin
                            // Empty product: go straight to the result cycle.
                            state   <= ST_OUT;
                            out_vld <= 1'b1;
                        end else begin
                            state <= ST_MAC;
                        end
                    end
                end
                ST_MAC: begin
                    if (last_k) begin
                        // Final slice always closes a chunk, even a partial one.
                        state    <= ST_OUT;
                        out_vld  <= 1'b1;
                        pe_shift <= 1'b1;
                        k        <= '0;
                        chunk    <= '0;
                    end else begin
                        k <= k + K_W'(1);
                        if (chunk == CHUNK_LAST) begin
                            chunk    <= '0;
                            pe_shift <= 1'b1;
                        end else begin
                            chunk <= chunk + C_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign O_BUSY     = (state != ST_IDLE);
    assign O_PE_SHIFT = pe_shift;
    assign O_OUT_VLD  = out_vld;

    for (genvar i = 0; i < SA_R; i++) begin : g_row
        for (genvar j = 0; j < SA_C; j++) begin : g_col
            logic signed [2*D_W-1:0] prod;
            logic signed [ACC_W-1:0] acc;
            logic signed [ACC_W-1:0] acc_next;
            logic signed [D_W-1:0]   res;

            assign prod     = x_col[i] * w_row[j];
            assign acc_next = acc + {{(ACC_W-2*D_W){prod[2*D_W-1]}}, prod};

            // Per-cell accumulator: cleared at start, advanced each MAC cycle.
            always_ff @(posedge I_CLK) begin
                if (!I_SYNC_RSTN) begin
                    acc <= '0;
                end else if (start_acc) begin
                    acc <= '0;
                end else if (state == ST_MAC) begin
                    acc <= acc_next;
                end
            end

            // Result register: loaded from the final sum so it is valid with O_OUT_VLD.
            always_ff @(posedge I_CLK) begin
                if (!I_SYNC_RSTN) begin
                    res <= '0;
                end else if (load_zero) begin
                    res <= '0;
                end else if (last_k) begin
                    res <= saturate(acc_next);
                end
            end

            assign O_OUT[(i*SA_C + j)*D_W +: D_W] = res;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sa_mm_responder.sv
// ============================================================================
//  Module   : tb_sa_mm_responder
//  Brief    : Self-checking bench for sa_mm_responder (FRAC=0 and FRAC=4
//             instances share stimulus) with a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sa_mm_responder;

    localparam int D_W   = 8;
    localparam int SA_R  = 16;
    localparam int SA_C  = 16;
    localparam int K_MAX = 128;
    localparam int XW    = SA_R*K_MAX*D_W;
    localparam int WW    = K_MAX*SA_C*D_W;
    localparam int OW    = SA_R*SA_C*D_W;
    localparam int NCYC  = 4096;

    logic          clk   = 1'b0;
    logic          rstn  = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    m_dim = '0;
    logic [XW-1:0] x_vec = '0;
    logic [WW-1:0] w_vec = '0;

    logic          busy0, pe0, vld0, busy4, pe4, vld4;
    logic [OW-1:0] out0, out4;

    sa_mm_responder #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX), .FRAC(0)) dut0 (
        .I_CLK(clk), .I_SYNC_RSTN(rstn), .I_START_FLAG(start), .I_M_DIM(m_dim),
        .I_X_MATRIX(x_vec), .I_W_MATRIX(w_vec),
        .O_BUSY(busy0), .O_PE_SHIFT(pe0), .O_OUT_VLD(vld0), .O_OUT(out0)
    );

    sa_mm_responder #(.D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .K_MAX(K_MAX), .FRAC(4)) dut4 (
        .I_CLK(clk), .I_SYNC_RSTN(rstn), .I_START_FLAG(start), .I_M_DIM(m_dim),
        .I_X_MATRIX(x_vec), .I_W_MATRIX(w_vec),
        .O_BUSY(busy4), .O_PE_SHIFT(pe4), .O_OUT_VLD(vld4), .O_OUT(out4)
    );

    always #5 clk = ~clk;

    // Operand matrices in natural form; packed into x_vec/w_vec by pack().
    logic signed [7:0] xs [SA_R][K_MAX];
    logic signed [7:0] ws [K_MAX][SA_C];

    // Reference model state.
    int            cyc      = 0;
    bit            m_active = 1'b0;
    int            m_c0     = 0;
    int            m_end    = 0;
    int            mm;
    int            ss;
    logic [OW-1:0] exp0 = '0;
    logic [OW-1:0] exp4 = '0;
    logic [OW-1:0] res0 = '0;
    logic [OW-1:0] res4 = '0;
    bit            pe_mark [NCYC];

    // Observation / scoring.
    bit            chk_en  = 1'b0;
    int            vld_cyc = -1;
    int            pe_seen [$];
    int            n_cmp   = 0;
    int            n_bad   = 0;
    bit            exp_busy, exp_vld, exp_pe;

    function automatic logic [7:0] sat8(input int v);
        if (v > 127)  return 8'h7F;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    task automatic chk1(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, got, want);
        end
    endtask

    task automatic chk_out(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] want);
        bit shown;
        shown = 1'b0;
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            for (int e = 0; e < SA_R*SA_C; e++) begin
                if (!shown && (got[e*8 +: 8] !== want[e*8 +: 8])) begin
                    $display("FAIL %s @cyc %0d elem %0d: got %h want %h",
                             nm, cyc, e, got[e*8 +: 8], want[e*8 +: 8]);
                    shown = 1'b1;
                end
            end
        end
    endtask

    task automatic pack();
        for (int i = 0; i < SA_R; i++)
            for (int k = 0; k < K_MAX; k++)
                x_vec[(i*K_MAX + k)*D_W +: D_W] = xs[i][k];
        for (int k = 0; k < K_MAX; k++)
            for (int j = 0; j < SA_C; j++)
                w_vec[(k*SA_C + j)*D_W +: D_W] = ws[k][j];
    endtask

    // Model: on each edge decide acceptance, compute the full product and schedule outputs.
    initial forever begin
        @(posedge clk);
        if (!rstn) begin
            m_active = 1'b0;
            exp0 = '0;
            exp4 = '0;
            for (int c = cyc + 1; c < NCYC; c++) pe_mark[c] = 1'b0;
        end else if (start && !(m_active && cyc <= m_end)) begin
            mm = (int'(m_dim) < K_MAX) ? int'(m_dim) : K_MAX;
            m_active = 1'b1;
            m_c0  = cyc;
            m_end = cyc + mm + 1;
            for (int i = 0; i < SA_R; i++) begin
                for (int j = 0; j < SA_C; j++) begin
                    ss = 0;
                    for (int k = 0; k < mm; k++) ss += int'(xs[i][k]) * int'(ws[k][j]);
                    res0[(i*SA_C + j)*8 +: 8] = sat8(ss);
                    res4[(i*SA_C + j)*8 +: 8] = sat8(ss >>> 4);
                end
            end
            for (int k = 0; k < mm; k++)
                if ((k % SA_C == SA_C - 1) || (k == mm - 1)) pe_mark[cyc + k + 2] = 1'b1;
        end
        cyc++;
        if (m_active && cyc == m_end) begin
            exp0 = res0;
            exp4 = res4;
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            exp_busy = m_active && (cyc > m_c0) && (cyc <= m_end);
            exp_vld  = m_active && (cyc == m_end);
            exp_pe   = (cyc < NCYC) ? pe_mark[cyc] : 1'b0;
            chk1("busy0", 32'(busy0), 32'(exp_busy));
            chk1("busy4", 32'(busy4), 32'(exp_busy));
            chk1("pe0",   32'(pe0),   32'(exp_pe));
            chk1("pe4",   32'(pe4),   32'(exp_pe));
            chk1("vld0",  32'(vld0),  32'(exp_vld));
            chk1("vld4",  32'(vld4),  32'(exp_vld));
            chk_out("out0", out0, exp0);
            chk_out("out4", out4, exp4);
            if (vld0) vld_cyc = cyc;
            if (pe0)  pe_seen.push_back(cyc);
        end
    end

    // Issue one start in the current cycle and wait (bounded) for its valid.
    task automatic do_run(input int m, output int c0);
        int n;
        n = 0;
        m_dim = m[7:0];
        start = 1'b1;
        c0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        m_dim = 8'hA5;
        while (vld_cyc <= c0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (vld_cyc <= c0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout m=%0d c0=%0d: got no valid want valid", m, c0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, prev_vld, c_b;

        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn   = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk_out("reset_out0", out0, '0);

        // T1/T2: {2,1,2,3..15} rows and columns, M=16 -> 1244.
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < SA_R; i++)
                xs[i][k] = (k == 0) ? 8'sd2 : (k < 16) ? 8'(k) : 8'sd9;
            for (int j = 0; j < SA_C; j++)
                ws[k][j] = (k == 0) ? 8'sd2 : (k < 16) ? 8'(k) : -8'sd7;
        end
        pack();
        do_run(16, c0);
        chk1("t1_latency", 32'(vld_cyc - c0), 32'd17);
        chk1("t1_out0_first", 32'(out0[7:0]), 32'h7F);
        chk1("t1_out0_last", 32'(out0[OW-1 -: 8]), 32'h7F);
        chk1("t1_model0", 32'(exp0[7:0]), 32'h7F);
        chk1("t2_out4", 32'(out4[7:0]), 32'd77);
        chk1("t2_model4", 32'(exp4[15:8]), 32'd77);

        // T3: X=-1, W=127, M=16 -> -2032.
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < SA_R; i++) xs[i][k] = -8'sd1;
            for (int j = 0; j < SA_C; j++) ws[k][j] = 8'sd127;
        end
        pack();
        do_run(16, c0);
        chk1("t3_out0", 32'(out0[7:0]), 32'h80);
        chk1("t3_out4", 32'(out4[7:0]), 32'h81);

        // T4: mixed-sign pattern, M=40 -> three chunk pulses.
        for (int k = 0; k < K_MAX; k++) begin
            for (int i = 0; i < SA_R; i++) xs[i][k] = 8'(((i*5 + k*3) % 13) - 6);
            for (int j = 0; j < SA_C; j++) ws[k][j] = 8'(((k*7 + j*2) % 11) - 5);
        end
        pack();
        pe_seen.delete();
        do_run(40, c0);
        chk1("t4_latency", 32'(vld_cyc - c0), 32'd41);
        chk1("t4_pe_count", 32'(pe_seen.size()), 32'd3);
        if (pe_seen.size() == 3) begin
            chk1("t4_pe_a", 32'(pe_seen[0] - c0), 32'd17);
            chk1("t4_pe_b", 32'(pe_seen[1] - c0), 32'd33);
            chk1("t4_pe_c", 32'(pe_seen[2] - c0), 32'd41);
        end

        // T5: M=0 then clamped M=200.
        pe_seen.delete();
        do_run(0, c0);
        chk1("t5_m0_latency", 32'(vld_cyc - c0), 32'd1);
        chk1("t5_m0_no_pe", 32'(pe_seen.size()), 32'd0);
        chk1("t5_m0_zero", 32'(out0 == '0), 32'd1);
        do_run(200, c0);
        chk1("t5_clamp_latency", 32'(vld_cyc - c0), 32'd129);

        // Back-to-back: restart in the cycle right after valid.
        do_run(2, c0);
        prev_vld = vld_cyc;
        do_run(1, c_b);
        chk1("b2b_start_cycle", 32'(c_b - prev_vld), 32'd1);
        chk1("b2b_latency", 32'(vld_cyc - c_b), 32'd2);

        // T6: re-pulse ignored, reset aborts the run, then a new start works.
        @(posedge clk); #1;
        prev_vld = vld_cyc;
        m_dim = 8'd20;
        start = 1'b1;
        c0    = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        m_dim = 8'h55;
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk1("t6_reset_busy", 32'(busy0), 32'd0);
        chk_out("t6_reset_out", out0, '0);
        repeat (25) @(posedge clk);
        #1;
        chk1("t6_no_vld", 32'(vld_cyc), 32'(prev_vld));
        do_run(3, c0);
        chk1("t6_after_reset_latency", 32'(vld_cyc - c0), 32'd4);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
